stream_source: RTL and testbench

Synthesizable stimulus transmitter for the filter's `vIn`/`dIn` input stream: the sending end of the protocol that `data_sink` receives on the filter output.
- Holds a loadable sample memory and the filter coefficient registers.
- Replays the samples with a programmable idle gap between them.
- Asserts `end_sim` after a fixed drain interval.
- Replaces the file-based `data_maker` in the filter bench, and sits in front of `iir_filter` on an FPGA/emulation build.

---
 rtl/stream_source_pkg.sv | 25 ++
 rtl/stream_source_sample_ram.sv | 24 ++
 rtl/stream_source.sv | 166 ++++++++++++++++
 tb/tb_stream_source.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_source_pkg.sv
// Shared definitions for the filter stimulus source: FSM states,
// coefficient select codes and parameter defaults.
package stream_source_pkg;

    localparam int NB_DEFAULT    = 12;
    localparam int DRAIN_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_SEND,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Coefficient select codes; 5..7 address nothing.
    localparam logic [2:0] SEL_B0 = 3'd0;
    localparam logic [2:0] SEL_B1 = 3'd1;
    localparam logic [2:0] SEL_B2 = 3'd2;
    localparam logic [2:0] SEL_A1 = 3'd3;
    localparam logic [2:0] SEL_A2 = 3'd4;
    localparam int         NUM_COEF = 5;

endpackage

// File: rtl/stream_source_sample_ram.sv
// Single-clock sample memory: one write port, one registered read port.
// Contents are intentionally not reset so they survive a reset mid-run.
module sample_ram #(
    parameter int NB = 12,
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [NB-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [NB-1:0] rd_data
);

    logic [NB-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/stream_source.sv
// Stimulus transmitter for the filter input stream: replays a loaded sample
// memory with a programmable gap, then drains and raises end_sim.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int NB    = NB_DEFAULT,
    parameter int AW    = 8,
    parameter int DRAIN = DRAIN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load_we,
    input  logic [AW-1:0]   load_addr,
    input  logic [NB-1:0]   load_data,
    input  logic            coef_we,
    input  logic [2:0]      coef_sel,
    input  logic [NB-1:0]   coef_data,
    input  logic            start,
    input  logic [AW:0]     length,
    input  logic [3:0]      gap,
    output logic            vOut,
    output logic [NB-1:0]   dOut,
    output logic [3*NB-1:0] b,
    output logic [2*NB-1:0] a,
    output logic            busy,
    output logic            end_sim
);

    localparam int DEPTH = 2**AW;
    // One counter serves both the gap (up to 15) and the drain interval.
    localparam int CW = ($clog2(DRAIN + 1) > 4) ? $clog2(DRAIN + 1) : 4;

    state_e          state_reg;
    logic [AW:0]     len_reg;
    logic [3:0]      gap_reg;
    logic [AW-1:0]   idx_reg;
    logic [CW-1:0]   cnt_reg;
    logic            v_out_reg;
    logic [NB-1:0]   d_out_reg;
    logic            busy_reg;
    logic            end_sim_reg;

    logic                 wr_ok;
    logic                 last_idx;
    logic [AW:0]          len_clamped;
    logic [AW-1:0]        rd_addr;
    logic [NB-1:0]        rd_data;
    logic [NUM_COEF*NB-1:0] coef_vec;

    assign wr_ok       = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign len_clamped = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
    assign last_idx    = ({1'b0, idx_reg} == (len_reg - (AW+1)'(1)));

    // Prefetch idx+1 while sending so back-to-back samples need no bubble.
    always_comb begin
        rd_addr = idx_reg;
        if (state_reg == ST_SEND) begin
            rd_addr = idx_reg + AW'(1);
        end
    end

    sample_ram #(
        .NB (NB),
        .AW (AW)
    ) u_sample_ram (
        .clock   (clock),
        .we      (load_we && wr_ok),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            len_reg     <= '0;
            gap_reg     <= '0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            v_out_reg   <= 1'b0;
            d_out_reg   <= '0;
            busy_reg    <= 1'b0;
            end_sim_reg <= 1'b0;
        end else begin
            v_out_reg <= (state_reg == ST_SEND);
            if (state_reg == ST_SEND) begin
                d_out_reg <= rd_data;
            end
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len_reg     <= len_clamped;
                        gap_reg     <= gap;
                        idx_reg     <= '0;
                        cnt_reg     <= '0;
                        end_sim_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= (length == '0) ? ST_DRAIN : ST_PREP;
                    end
                end
                ST_PREP: begin
                    state_reg <= ST_SEND;
                end
                ST_SEND: begin
                    idx_reg <= idx_reg + AW'(1);
                    cnt_reg <= '0;
                    if (last_idx) begin
                        state_reg <= ST_DRAIN;
                    end else if (gap_reg != 4'd0) begin
                        state_reg <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == CW'(gap_reg) - CW'(1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_SEND;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    // DRAIN+1 cycles here: the registered vOut trails SEND by one.
                    if (cnt_reg == CW'(DRAIN)) begin
                        cnt_reg     <= '0;
                        end_sim_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEF; gi++) begin : g_coef
            logic [NB-1:0] coef_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    coef_q <= '0;
                end else if (coef_we && wr_ok && (coef_sel == 3'(gi))) begin
                    coef_q <= coef_data;
                end
            end
            assign coef_vec[gi*NB +: NB] = coef_q;
        end
    endgenerate

    assign b = {coef_vec[int'(SEL_B2)*NB +: NB],
                coef_vec[int'(SEL_B1)*NB +: NB],
                coef_vec[int'(SEL_B0)*NB +: NB]};
    assign a = {coef_vec[int'(SEL_A2)*NB +: NB],
                coef_vec[int'(SEL_A1)*NB +: NB]};

    assign vOut    = v_out_reg;
    assign dOut    = d_out_reg;
    assign busy    = busy_reg;
    assign end_sim = end_sim_reg;

endmodule

// File: tb/tb_stream_source.sv
// Randomized self-checking bench for stream_source against a timing/content
// model derived from start latency, gap spacing and drain rules.
module tb_stream_source;

    localparam int NB    = 12;
    localparam int AW    = 8;
    localparam int DRAIN = 16;
    localparam int DEPTH = 256;

    logic            clock;
    logic            reset_n;
    logic            load_we;
    logic [AW-1:0]   load_addr;
    logic [NB-1:0]   load_data;
    logic            coef_we;
    logic [2:0]      coef_sel;
    logic [NB-1:0]   coef_data;
    logic            start;
    logic [AW:0]     length;
    logic [3:0]      gap;
    logic            vOut;
    logic [NB-1:0]   dOut;
    logic [3*NB-1:0] b;
    logic [2*NB-1:0] a;
    logic            busy;
    logic            end_sim;

    stream_source #(.NB(NB), .AW(AW), .DRAIN(DRAIN)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .coef_we   (coef_we),
        .coef_sel  (coef_sel),
        .coef_data (coef_data),
        .start     (start),
        .length    (length),
        .gap       (gap),
        .vOut      (vOut),
        .dOut      (dOut),
        .b         (b),
        .a         (a),
        .busy      (busy),
        .end_sim   (end_sim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [NB-1:0] mem_model  [DEPTH];
    logic [NB-1:0] coef_model [5];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_coefs(input string tag);
        check_val({tag, "_b"}, 64'(b), 64'({coef_model[2], coef_model[1], coef_model[0]}));
        check_val({tag, "_a"}, 64'(a), 64'({coef_model[4], coef_model[3]}));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_vout"}, 64'(vOut), 0);
        check_val({tag, "_dout"}, 64'(dOut), 0);
        check_val({tag, "_b"}, 64'(b), 0);
        check_val({tag, "_a"}, 64'(a), 0);
        check_val({tag, "_busy"}, 64'(busy), 0);
        check_val({tag, "_end_sim"}, 64'(end_sim), 0);
    endtask

    task automatic write_mem(input int addr, input logic [NB-1:0] data);
        load_we   = 1'b1;
        load_addr = addr[AW-1:0];
        load_data = data;
        @(posedge clock); #1;
        load_we = 1'b0;
        mem_model[addr] = data;
    endtask

    task automatic write_coef(input int sel, input logic [NB-1:0] data);
        coef_we   = 1'b1;
        coef_sel  = sel[2:0];
        coef_data = data;
        @(posedge clock); #1;
        coef_we = 1'b0;
        if (sel < 5) coef_model[sel] = data;
    endtask

    // Starts a run and follows it cycle by cycle to end_sim. Cycle n counts
    // clock edges after the start edge; sample k is due at n = 2 + k*(gap+1).
    task automatic do_run(input int len, input int g, input bit try_ignored);
        int  exp_len;
        int  exp_end;
        int  k;
        bit  done_f;
        exp_len = (len > DEPTH) ? DEPTH : len;
        exp_end = (exp_len == 0) ? DRAIN + 1 : 2 + (exp_len - 1) * (g + 1) + DRAIN + 1;
        start  = 1'b1;
        length = len[AW:0];
        gap    = g[3:0];
        @(posedge clock); #1;
        start = 1'b0;
        check_val("busy_on_start", 64'(busy), 1);
        check_val("end_sim_cleared", 64'(end_sim), 0);
        k = 0;
        done_f = 1'b0;
        for (int n = 1; n < 6000 && !done_f; n++) begin
            if (try_ignored && n == 3) begin
                load_we   = 1'b1;
                load_addr = '0;
                load_data = ~mem_model[0];
                coef_we   = 1'b1;
                coef_sel  = 3'd0;
                coef_data = ~coef_model[0];
                start     = 1'b1;
                length    = 9'd1;
            end else if (try_ignored && n == 4) begin
                load_we = 1'b0;
                coef_we = 1'b0;
                start   = 1'b0;
            end
            @(posedge clock); #1;
            if (vOut) begin
                if (k < exp_len) begin
                    check_val("sample_data", 64'(dOut), 64'(mem_model[k]));
                    check_val("sample_time", 64'(n), 64'(2 + k * (g + 1)));
                end else begin
                    check_val("extra_sample", 64'(k), 64'(exp_len));
                end
                k++;
            end else if (k > 0) begin
                check_val("dout_hold", 64'(dOut), 64'(mem_model[k-1]));
            end
            check_val("busy_vs_end_sim", 64'(busy), 64'(!end_sim));
            if (end_sim) begin
                check_val("end_sim_time", 64'(n), 64'(exp_end));
                done_f = 1'b1;
            end
        end
        if (!done_f) check_val("run_timeout", 0, 1);
        check_val("sample_count", 64'(k), 64'(exp_len));
        $display("run len=%0d gap=%0d: %0d samples, end_sim at cycle %0d", len, g, k, exp_end);
    endtask

    initial begin
        reset_n = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        coef_we = 1'b0; coef_sel = '0; coef_data = '0;
        start = 1'b0; length = '0; gap = '0;
        for (int i = 0; i < 5; i++) coef_model[i] = '0;

        repeat (3) begin
            @(posedge clock); #1;
            check_reset_outputs("reset");
        end
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < DEPTH; i++) write_mem(i, NB'($urandom));
        write_mem(0, 12'h001);
        write_mem(1, 12'h7FF);
        write_mem(2, 12'h800);
        write_mem(3, 12'hFFF);

        do_run(4, 0, 1'b0);
        do_run(3, 3, 1'b0);
        check_val("gap_hold_last", 64'(dOut), 64'h800);

        write_coef(0, 12'h123);
        write_coef(2, 12'hABC);
        write_coef(3, 12'h456);
        write_coef(6, 12'hFFF);
        check_val("coef_b_const", 64'(b), 64'h0_ABC0_0012_3);
        check_val("coef_a_const", 64'(a), 64'h000456);
        check_coefs("coef_model");

        do_run(0, 0, 1'b1);
        check_coefs("ignored_coef");
        do_run(4, 0, 1'b0);

        do_run(300, 0, 1'b0);
        do_run(5, 1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 3; w++) write_mem(int'($urandom_range(0, 31)), NB'($urandom));
            write_coef(int'($urandom_range(0, 7)), NB'($urandom));
            check_coefs("rand_coef");
            do_run(int'($urandom_range(0, 24)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run, then replay the retained memory.
        start = 1'b1; length = 9'd4; gap = 4'd2;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("midrun_vout_before", 64'(vOut), 1);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) coef_model[i] = '0;
        check_reset_outputs("midrun_reset");
        @(posedge clock); #1;
        check_reset_outputs("midrun_hold");
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_run(4, 0, 1'b0);
        check_coefs("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
